// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing and the decoder lock-state type.
// Imported by the vga timing generator and by vga_sync_decoder.
package vga_timing_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = 800;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = 525;

  // First pixel / first line on which the sync pulse is asserted
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int V_SYNC_START = V_VIS + V_FP;

  // 0 = negative-polarity sync
  localparam bit SYNC_ACTIVE = 1'b0;
  localparam int LOCK_LINES  = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HLOCK  = 2'd1,
    VWAIT  = 2'd2,
    LOCKED = 2'd3
  } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Turns one sync input into a single-sample "sync became active" pulse.
// With VGA_DEC_SYNC_INPUT_EN defined the input is first re-timed by a
// 2-flop synchronizer on clk, so an asynchronous sync source is safe.
module sync_edge_detect #(
  parameter bit ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic sync_in,
  output logic edge_pulse
);

  logic sampled;
  logic prev;

`ifdef VGA_DEC_SYNC_INPUT_EN
  logic meta;
  logic stable;

  // Two-stage synchronizer, runs every clk and idles at the inactive level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= ~ACTIVE;
      stable <= ~ACTIVE;
    end else begin
      meta   <= sync_in;
      stable <= meta;
    end
  end

  assign sampled = stable;
`else
  assign sampled = sync_in;
`endif

  // Remember the level seen on the previous pixel strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= ~ACTIVE;
    end else if (pix_en) begin
      prev <= sampled;
    end
  end

  assign edge_pulse = pix_en && (sampled == ACTIVE) && (prev != ACTIVE);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers raster coordinates from hsync/vsync sampled on a pixel strobe.
// A lock FSM (SEARCH -> HLOCK -> VWAIT -> LOCKED) qualifies the timing
// before the coordinates are trusted; a watchdog catches missing hsync.
// Optional input synchronizers: define VGA_DEC_SYNC_INPUT_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_VIS       = vga_timing_pkg::H_VIS,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_VIS       = vga_timing_pkg::V_VIS,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter bit SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE,
  parameter int LOCK_LINES  = vga_timing_pkg::LOCK_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  output logic [11:0] hdata,
  output logic [11:0] vdata,
  output logic        valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int HS_START = H_VIS + H_FP;
  localparam int VS_START = V_VIS + V_FP;
  localparam int WD_LIMIT = 2 * H_TOTAL;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  // A sync pulse that runs past the end of the line cannot be decoded
  if (HS_START + H_SYNC > H_TOTAL || VS_START >= V_TOTAL) begin : g_bad_timing
    $error("vga_sync_decoder: inconsistent timing parameters");
  end

  lock_state_t     state, state_n;
  logic [11:0]     hcnt, vcnt, h_next, v_next, hcnt_n, vcnt_n;
  logic [7:0]      good_lines, good_n;
  logic [WD_W-1:0] wd, wd_tick, wd_n;
  logic            hs_edge, vs_edge, h_wrap, v_wrap;
  logic            hs_bad, vs_bad, timeout;
  logic            err_n, frame_n, valid_n;

  sync_edge_detect #(.ACTIVE(SYNC_ACTIVE)) u_hs_edge (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .sync_in    (hsync),
    .edge_pulse (hs_edge)
  );

  sync_edge_detect #(.ACTIVE(SYNC_ACTIVE)) u_vs_edge (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .sync_in    (vsync),
    .edge_pulse (vs_edge)
  );

  // Free-running raster counters, re-aligned on each sync edge, plus the hsync watchdog
  always_comb begin
    h_wrap  = (hcnt == 12'(H_TOTAL - 1));
    v_wrap  = (vcnt == 12'(V_TOTAL - 1));
    h_next  = h_wrap ? 12'd0 : hcnt + 12'd1;
    v_next  = vcnt;
    if (h_wrap) begin
      v_next = v_wrap ? 12'd0 : vcnt + 12'd1;
    end
    hcnt_n  = hs_edge ? 12'(HS_START) : h_next;
    vcnt_n  = vs_edge ? 12'(VS_START) : v_next;
    hs_bad  = hs_edge && (h_next != 12'(HS_START));
    vs_bad  = vs_edge && (v_next != 12'(VS_START));
    wd_tick = wd + WD_W'(1);
    timeout = !hs_edge && (wd_tick == WD_W'(WD_LIMIT));
    wd_n    = (hs_edge || timeout) ? '0 : wd_tick;
  end

  // Lock FSM next state, plus the error / frame / visible decisions that depend on it
  always_comb begin
    state_n = state;
    good_n  = good_lines;
    err_n   = 1'b0;
    frame_n = 1'b0;
    valid_n = 1'b0;
    if (pix_en) begin
      case (state)
        SEARCH: begin
          if (hs_edge) begin
            state_n = HLOCK;
            good_n  = 8'd0;
          end
        end
        HLOCK: begin
          if (hs_edge) begin
            good_n = hs_bad ? 8'd0 : good_lines + 8'd1;
          end
          if (good_n == 8'(LOCK_LINES)) begin
            state_n = VWAIT;
          end
        end
        VWAIT: begin
          if (hs_bad) begin
            state_n = HLOCK;
            good_n  = 8'd0;
          end else if (vs_edge) begin
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (hs_bad || vs_bad) begin
            err_n   = 1'b1;
            state_n = HLOCK;
            good_n  = 8'd0;
          end
        end
        default: begin
          state_n = SEARCH;
          good_n  = 8'd0;
        end
      endcase
      if (timeout) begin
        err_n   = (state == LOCKED);
        state_n = SEARCH;
        good_n  = 8'd0;
      end
      frame_n = (state == LOCKED) && (state_n == LOCKED) && h_wrap &&
                (hcnt_n == 12'd0) && (vcnt_n == 12'd0);
      valid_n = (state_n == LOCKED) && (hcnt_n < 12'(H_VIS)) && (vcnt_n < 12'(V_VIS));
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
    end else begin
      state <= state_n;
    end
  end

  // Counters and registered outputs; pulses last one clk, everything else holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      good_lines  <= '0;
      wd          <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_start <= 1'b0;
      err         <= 1'b0;
      if (pix_en) begin
        hcnt        <= hcnt_n;
        vcnt        <= vcnt_n;
        good_lines  <= good_n;
        wd          <= wd_n;
        valid       <= valid_n;
        locked      <= (state_n == LOCKED);
        frame_start <= frame_n;
        err         <= err_n;
        if (err_n && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

  assign hdata = hcnt;
  assign vdata = vcnt;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster
// (16 px/line, 12 lines/frame) so full frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HV  = 8;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HT  = 16;
  localparam int VV  = 6;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VT  = 12;
  localparam int HSS = HV + HF;
  localparam int VSS = VV + VF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] hdata, vdata;
  logic        valid, frame_start, locked, err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int gh = 0, gv = 0, sh = 0, sv = 0;
  bit vs_late = 1'b0;
  int sat_errs = 0;

  vga_sync_decoder #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_VIS(VV), .V_FP(VF), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b0), .LOCK_LINES(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .hdata(hdata), .vdata(vdata), .valid(valid), .frame_start(frame_start),
    .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // One pixel strobe; returns 1 time unit after the sampling edge
  task automatic pix(input logic hs, input logic vs);
    @(negedge clk);
    hsync  = hs;
    vsync  = vs;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
  endtask

  // One pixel of the reference generator; sh/sv hold the position just sent
  task automatic gen_pix(input bit hs_off);
    logic hs, vs;
    int   vstart;
    vstart = VSS + (vs_late ? 1 : 0);
    hs = (gh >= HSS && gh < HSS + HSW) ? 1'b0 : 1'b1;
    if (hs_off) hs = 1'b1;
    vs = (gv >= vstart && gv < vstart + VSW) ? 1'b0 : 1'b1;
    pix(hs, vs);
    sh = gh;
    sv = gv;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) begin
        gv = 0;
        vs_late = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (hdata !== 12'd0 || vdata !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_coords: got h=%0d v=%0d, expected 0 0", hdata, vdata);
    end
    checks++;
    if ({valid, frame_start, locked, err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000", {valid, frame_start, locked, err});
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_err_count: got %0d, expected 0", err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    int first = -1;
    int pulses = 0;
    logic [11:0] lh = '0, lv = '0;
    for (int n = 0; n < 400 && first < 0; n++) begin
      gen_pix(1'b0);
      if (err || frame_start) pulses++;
      if (locked) begin
        first = n;
        lh = hdata;
        lv = vdata;
      end
    end
    checks++;
    if (first != 128) begin
      errors++;
      $display("[TB] FAIL lock_time: got sample %0d, expected 128", first);
    end
    checks++;
    if (lh !== 12'd0 || lv !== 12'(VSS)) begin
      errors++;
      $display("[TB] FAIL lock_coords: got h=%0d v=%0d, expected 0 %0d", lh, lv, VSS);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL lock_pulses: got %0d err/frame pulses, expected 0", pulses);
    end
  endtask

  task automatic test_tracking();
    int vcount = 0, fcount = 0, fh = -1, fv = -1;
    logic exp_valid;
    for (int n = 0; n < HT * VT; n++) begin
      gen_pix(1'b0);
      exp_valid = (sh < HV) && (sv < VV);
      checks++;
      if (hdata !== 12'(sh) || vdata !== 12'(sv)) begin
        errors++;
        $display("[TB] FAIL track_coords: got h=%0d v=%0d, expected %0d %0d", hdata, vdata, sh, sv);
      end
      checks++;
      if (valid !== exp_valid || locked !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL track_flags at %0d,%0d: got valid=%b locked=%b err=%b, expected %b 1 0",
                 sh, sv, valid, locked, err, exp_valid);
      end
      if (valid) vcount++;
      if (frame_start) begin
        fcount++;
        fh = sh;
        fv = sv;
      end
    end
    checks++;
    if (vcount != HV * VV) begin
      errors++;
      $display("[TB] FAIL valid_count: got %0d, expected %0d", vcount, HV * VV);
    end
    checks++;
    if (fcount != 1 || fh != 0 || fv != 0) begin
      errors++;
      $display("[TB] FAIL frame_start: got %0d pulses last at %0d,%0d, expected 1 at 0,0", fcount, fh, fv);
    end
  endtask

  task automatic test_hold();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      hsync  = 1'b0;
      vsync  = 1'b0;
      pix_en = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (hdata !== 12'(sh) || vdata !== 12'(sv) || {locked, err, frame_start} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL hold: got h=%0d v=%0d lock/err/fs=%b, expected %0d %0d 100",
                 hdata, vdata, {locked, err, frame_start}, sh, sv);
      end
    end
    for (int n = 0; n < 20; n++) begin
      gen_pix(1'b0);
      checks++;
      if (hdata !== 12'(sh) || vdata !== 12'(sv) || locked !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold_resume: got h=%0d v=%0d locked=%b, expected %0d %0d 1",
                 hdata, vdata, locked, sh, sv);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int first = -1;
    do begin
      gen_pix(1'b0);
      n++;
    end while (sh != 5 && n < 40);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (hdata !== 12'd0 || vdata !== 12'd0 || {valid, locked, err, frame_start} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_async: got h=%0d v=%0d flags=%b, expected 0 0 0000",
               hdata, vdata, {valid, locked, err, frame_start});
    end
    @(posedge clk);
    #1;
    checks++;
    if (hdata !== 12'd0 || locked !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midreset_clk: got h=%0d locked=%b errc=%0d, expected 0 0 0", hdata, locked, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5 * HT + HT * VT && first < 0; k++) begin
      gen_pix(1'b0);
      if (locked) first = k;
    end
    checks++;
    if (first < 0 || hdata !== 12'(sh) || vdata !== 12'(sv)) begin
      errors++;
      $display("[TB] FAIL relock_after_reset: got sample %0d h=%0d v=%0d, expected lock at %0d %0d",
               first, hdata, vdata, sh, sv);
    end
  endtask

  task automatic test_short_line();
    int n = 0;
    int pulses = 0;
    int first = -1;
    while (!(gh == 0 && gv == 1) && n < 300) begin
      gen_pix(1'b0);
      n++;
    end
    do begin
      gen_pix(1'b0);
      if (sh == 3) gh = 5;
      if (sh != HSS) begin
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL short_before: got locked=%b err=%b at h=%0d, expected 1 0", locked, err, sh);
        end
      end
    end while (sh != HSS && gh < HT && gh != 0);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL short_line: got err=%b locked=%b errc=%0d, expected 1 0 1", err, locked, err_count);
    end
    for (int k = 0; k < 300 && first < 0; k++) begin
      gen_pix(1'b0);
      if (err) pulses++;
      if (locked) first = k;
    end
    checks++;
    if (first < 0 || sh != 0 || sv != VSS || pulses != 0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL short_relock: got lock at %0d,%0d pulses=%0d errc=%0d, expected 0,%0d 0 1",
               sh, sv, pulses, err_count, VSS);
    end
  endtask

  task automatic test_vsync_late();
    int n = 0;
    int pulses = 0;
    int first = -1;
    while (!(gh == 0 && gv == 0) && n < 300) begin
      gen_pix(1'b0);
      n++;
    end
    vs_late = 1'b1;
    do begin
      gen_pix(1'b0);
      n++;
      if (!(sv == VSS + 1 && sh == 0)) begin
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL vlate_before: got locked=%b err=%b at %0d,%0d, expected 1 0", locked, err, sh, sv);
        end
      end
    end while (!(sv == VSS + 1 && sh == 0) && n < 600);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL vsync_late: got err=%b locked=%b errc=%0d, expected 1 0 2", err, locked, err_count);
    end
    for (int k = 0; k < 300 && first < 0; k++) begin
      gen_pix(1'b0);
      if (err) pulses++;
      if (locked) first = k;
    end
    checks++;
    if (first < 0 || sh != 0 || sv != VSS || pulses != 0 || vdata !== 12'(VSS)) begin
      errors++;
      $display("[TB] FAIL vlate_relock: got lock at %0d,%0d v=%0d pulses=%0d, expected 0,%0d %0d 0",
               sh, sv, vdata, pulses, VSS, VSS);
    end
  endtask

  task automatic test_watchdog();
    int n = 0;
    logic exp_err, exp_lock;
    while (!(sh == HSS && locked) && n < 64) begin
      gen_pix(1'b0);
      n++;
    end
    for (int k = 1; k <= 40; k++) begin
      gen_pix(1'b1);
      exp_err  = (k == 2 * HT);
      exp_lock = (k < 2 * HT);
      checks++;
      if (err !== exp_err || locked !== exp_lock) begin
        errors++;
        $display("[TB] FAIL watchdog at sample %0d: got err=%b locked=%b, expected %b %b",
                 k, err, locked, exp_err, exp_lock);
      end
    end
  endtask

  // Line with its hsync pulse 6 samples before the end; len 15 arrives one sample early
  task automatic sat_line(input int len, input bit vs_pulse);
    for (int h = 0; h < len; h++) begin
      pix((h >= len - 6 && h < len - 3) ? 1'b0 : 1'b1, (vs_pulse && h < 2) ? 1'b0 : 1'b1);
      if (err) sat_errs++;
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    hsync = 1'b1;
    vsync = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    sat_errs = 0;
    for (int i = 0; i < 300; i++) begin
      repeat (5) sat_line(HT, 1'b0);
      sat_line(HT, 1'b1);
      sat_line(HT - 1, 1'b0);
      if (i == 99) begin
        checks++;
        if (err_count !== 8'd100 || sat_errs != 100) begin
          errors++;
          $display("[TB] FAIL sat_100: got errc=%0d pulses=%0d, expected 100 100", err_count, sat_errs);
        end
      end
    end
    checks++;
    if (sat_errs != 300) begin
      errors++;
      $display("[TB] FAIL sat_pulses: got %0d, expected 300", sat_errs);
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_count: got %0d, expected 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tracking();
    test_hold();
    test_reset_midframe();
    test_short_line();
    test_vsync_late();
    test_watchdog();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
